// File: rtl/lc3_dmem_pkg.sv
// Shared types and constants for the LC3 data-memory responder.
//   lc3_word_t   : 16-bit LC3 data word
//   dmem_state_t : responder FSM states
//   LAT_MAX      : largest supported request-to-completion latency
package lc3_dmem_pkg;

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned LAT_MAX = 15;
  localparam int unsigned CNT_W   = $clog2(LAT_MAX + 1);

  typedef logic [WORD_W-1:0] lc3_word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/lc3_dmem_responder_if.sv
// LC3 MemAccess data-memory port.
//   master : the LC3 core side (drives request, address, write data)
//   slave  : the memory responder (drives read data and completion strobe)
interface lc3_dmem_responder_if;
  import lc3_dmem_pkg::*;

  logic      data_req;
  logic      data_rd;
  lc3_word_t data_addr;
  lc3_word_t data_din;
  lc3_word_t data_dout;
  logic      complete_data;

  modport master (
    output data_req, data_rd, data_addr, data_din,
    input  data_dout, complete_data
  );

  modport slave (
    input  data_req, data_rd, data_addr, data_din,
    output data_dout, complete_data
  );

endinterface

// File: rtl/lc3_dmem_array.sv
// Word-addressed storage for the responder: one synchronous write port shared
// between the preload side-band and DUT writes, one combinational read port.
// Contents are not reset.
//   clock      : write clock
//   ld_we_i    : preload write enable (ld_addr_i / ld_data_i)
//   wr_we_i    : DUT write enable (wr_addr_i / wr_data_i)
//   raddr_i    : read address
//   rdata_c_o  : combinational read data
module lc3_dmem_array
  import lc3_dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clock,
  input  logic              ld_we_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  lc3_word_t         ld_data_i,
  input  logic              wr_we_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  lc3_word_t         wr_data_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output lc3_word_t         rdata_c_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  lc3_word_t         mem_q [DEPTH];
  logic              we_c;
  logic [ADDR_W-1:0] waddr_c;
  lc3_word_t         wdata_c;

  // Preload and DUT write never coincide (IDLE vs DONE); preload takes the port.
  always_comb begin
    we_c    = ld_we_i | wr_we_i;
    waddr_c = wr_addr_i;
    wdata_c = wr_data_i;
    if (ld_we_i) begin
      waddr_c = ld_addr_i;
      wdata_c = ld_data_i;
    end
  end

  always_ff @(posedge clock) begin
    if (we_c) begin
      mem_q[waddr_c] <= wdata_c;
    end
  end

  assign rdata_c_o = mem_q[raddr_i];

endmodule

// File: rtl/lc3_dmem_responder.sv
// Data-memory responder for the LC3 MemAccess port. Accepts one request at a
// time, latches it, and completes it LATENCY cycles later with a one-cycle
// complete_data strobe; read data is registered and held until the next read.
// A side-band preload port writes the array while the responder is idle.
//   clock, reset_n : clock and asynchronous active-low reset
//   dmem           : data-memory port (slave side)
//   ld_en/ld_addr/ld_data : preload write, honoured only when idle
//   ld_err         : one-cycle pulse when a preload is dropped because busy
module lc3_dmem_responder
  import lc3_dmem_pkg::*;
#(
  parameter int unsigned ADDR_LSB_W = 8,
  parameter int unsigned LATENCY    = 2   // legal range 1..LAT_MAX
) (
  input  logic                   clock,
  input  logic                   reset_n,
  lc3_dmem_responder_if.slave    dmem,
  input  logic                   ld_en,
  input  logic [ADDR_LSB_W-1:0]  ld_addr,
  input  lc3_word_t              ld_data,
  output logic                   ld_err
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  dmem_state_t           state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  rd_q;
  logic [ADDR_LSB_W-1:0] addr_q;
  lc3_word_t             din_q;
  lc3_word_t             dout_q;
  logic                  complete_q;
  logic                  ld_err_q;

  logic                  ld_we_c;
  logic                  wr_we_c;
  lc3_word_t             rdata_c;

  // Address bits above the implemented depth alias onto the array.
  generate
    if (ADDR_LSB_W < WORD_W) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^dmem.data_addr[WORD_W-1:ADDR_LSB_W];
    end
  endgenerate

  assign ld_we_c = ld_en && (state_q == IDLE);
  // The write commits on the edge that leaves DONE, alongside the strobe.
  assign wr_we_c = (state_q == DONE) && !rd_q;

  lc3_dmem_array #(
    .ADDR_W (ADDR_LSB_W)
  ) u_array (
    .clock     (clock),
    .ld_we_i   (ld_we_c),
    .ld_addr_i (ld_addr),
    .ld_data_i (ld_data),
    .wr_we_i   (wr_we_c),
    .wr_addr_i (addr_q),
    .wr_data_i (din_q),
    .raddr_i   (addr_q),
    .rdata_c_o (rdata_c)
  );

  // FSM, latency counter, request latches and registered outputs.
  // complete_data is registered out of DONE, so an accept at edge N enters
  // DONE at N+LATENCY-1 and strobes at N+LATENCY; the strobe cycle is the
  // mandatory IDLE cycle, giving back-to-back completions every LATENCY+1.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      dout_q     <= '0;
      complete_q <= 1'b0;
      ld_err_q   <= 1'b0;
    end else begin
      complete_q <= 1'b0;
      ld_err_q   <= ld_en && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (dmem.data_req) begin
            rd_q    <= dmem.data_rd;
            addr_q  <= dmem.data_addr[ADDR_LSB_W-1:0];
            din_q   <= dmem.data_din;
            cnt_q   <= CNT_INIT;
            state_q <= (LATENCY == 1) ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (!dmem.data_req) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          complete_q <= 1'b1;
          if (rd_q) begin
            dout_q <= rdata_c;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmem.data_dout     = dout_q;
  assign dmem.complete_data = complete_q;
  assign ld_err             = ld_err_q;

endmodule

// File: tb/tb_lc3_dmem_responder.sv
// Scoreboard bench: two responders (LATENCY=2 and LATENCY=1) driven through
// their own interfaces; expected completions are queued when a request is
// issued and checked by a monitor when complete_data rises.
module tb_lc3_dmem_responder;
  import lc3_dmem_pkg::*;

  localparam int unsigned AW = 8;
  localparam int L0 = 2;
  localparam int L1 = 1;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  lc3_dmem_responder_if if0 ();
  lc3_dmem_responder_if if1 ();

  logic          ld_en0, ld_en1;
  logic [AW-1:0] ld_addr0, ld_addr1;
  lc3_word_t     ld_data0, ld_data1;
  logic          ld_err0, ld_err1;

  lc3_dmem_responder #(.ADDR_LSB_W(AW), .LATENCY(L0)) u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .dmem    (if0),
    .ld_en   (ld_en0),
    .ld_addr (ld_addr0),
    .ld_data (ld_data0),
    .ld_err  (ld_err0)
  );

  lc3_dmem_responder #(.ADDR_LSB_W(AW), .LATENCY(L1)) u_dut_l1 (
    .clock   (clock),
    .reset_n (reset_n),
    .dmem    (if1),
    .ld_en   (ld_en1),
    .ld_addr (ld_addr1),
    .ld_data (ld_data1),
    .ld_err  (ld_err1)
  );

  typedef struct {
    lc3_word_t dout;
    int        cyc;
  } exp_t;

  exp_t      q0[$];
  exp_t      q1[$];
  lc3_word_t mem0 [256];
  lc3_word_t mem1 [256];
  lc3_word_t md0 = '0;
  lc3_word_t md1 = '0;
  logic      prev_c0 = 1'b0;
  logic      prev_c1 = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Completion monitor: pops the scoreboard and checks data, timing, width.
  always @(negedge clock) begin
    exp_t e;
    if (if0.complete_data) begin
      check_eq("l2_strobe_width", 32'(prev_c0), 32'd0);
      if (q0.size() == 0) begin
        check_eq("l2_unexpected_complete", 32'(if0.complete_data), 32'd0);
      end else begin
        e = q0.pop_front();
        check_eq("l2_dout", 32'(if0.data_dout), 32'(e.dout));
        check_eq("l2_complete_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (if1.complete_data) begin
      check_eq("l1_strobe_width", 32'(prev_c1), 32'd0);
      if (q1.size() == 0) begin
        check_eq("l1_unexpected_complete", 32'(if1.complete_data), 32'd0);
      end else begin
        e = q1.pop_front();
        check_eq("l1_dout", 32'(if1.data_dout), 32'(e.dout));
        check_eq("l1_complete_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    prev_c0 = if0.complete_data;
    prev_c1 = if1.complete_data;
  end

  // Drive a request at a negedge; when expected to complete, update the model
  // and push the expected completion.
  task automatic start_req(input int sel, input logic rd, input lc3_word_t addr,
                           input lc3_word_t din, input logic expect_cmpl);
    exp_t     e;
    int       idx;
    idx   = int'(addr[AW-1:0]);
    e.cyc = cyc + 1 + ((sel == 0) ? L0 : L1);
    if (sel == 0) begin
      if0.data_req = 1'b1; if0.data_rd = rd; if0.data_addr = addr; if0.data_din = din;
      if (expect_cmpl) begin
        if (rd) md0 = mem0[idx]; else mem0[idx] = din;
        e.dout = md0;
        q0.push_back(e);
      end
    end else begin
      if1.data_req = 1'b1; if1.data_rd = rd; if1.data_addr = addr; if1.data_din = din;
      if (expect_cmpl) begin
        if (rd) md1 = mem1[idx]; else mem1[idx] = din;
        e.dout = md1;
        q1.push_back(e);
      end
    end
  endtask

  // Wait (bounded) for completion; scrambles the request fields after
  // acceptance, which the responder must ignore.
  task automatic wait_done(input int sel, output int at);
    logic c;
    at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      c = (sel == 0) ? if0.complete_data : if1.complete_data;
      if (c) begin
        at = cyc;
        break;
      end
      if (i == 0) begin
        if (sel == 0) begin
          if0.data_addr = 16'($urandom); if0.data_din = 16'($urandom); if0.data_rd = ~if0.data_rd;
        end else begin
          if1.data_addr = 16'($urandom); if1.data_din = 16'($urandom); if1.data_rd = ~if1.data_rd;
        end
      end
    end
    if (at < 0) check_eq("complete_timeout", 32'(c), 32'd1);
  endtask

  task automatic drop_req(input int sel);
    if (sel == 0) if0.data_req = 1'b0; else if1.data_req = 1'b0;
  endtask

  // Preload while the target responder is idle.
  task automatic preload(input int sel, input logic [AW-1:0] a, input lc3_word_t d);
    if (sel == 0) begin
      ld_en0 = 1'b1; ld_addr0 = a; ld_data0 = d; mem0[a] = d;
    end else begin
      ld_en1 = 1'b1; ld_addr1 = a; ld_data1 = d; mem1[a] = d;
    end
    @(negedge clock);
    ld_en0 = 1'b0;
    ld_en1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ta, tb;
    if0.data_req = 1'b0; if0.data_rd = 1'b0; if0.data_addr = '0; if0.data_din = '0;
    if1.data_req = 1'b0; if1.data_rd = 1'b0; if1.data_addr = '0; if1.data_din = '0;
    ld_en0 = 1'b0; ld_addr0 = '0; ld_data0 = '0;
    ld_en1 = 1'b0; ld_addr1 = '0; ld_data1 = '0;

    repeat (3) @(negedge clock);
    check_eq("rst_complete0", 32'(if0.complete_data), 32'd0);
    check_eq("rst_dout0",     32'(if0.data_dout),     32'h0000);
    check_eq("rst_ld_err0",   32'(ld_err0),           32'd0);
    check_eq("rst_complete1", 32'(if1.complete_data), 32'd0);
    check_eq("rst_dout1",     32'(if1.data_dout),     32'h0000);
    check_eq("rst_ld_err1",   32'(ld_err1),           32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    preload(0, 8'h10, 16'hBEEF);
    preload(0, 8'h30, 16'h5555);
    preload(0, 8'h40, 16'h4444);
    preload(0, 8'h50, 16'h1111);

    // Read of a preloaded word, then strobe must fall after one cycle.
    start_req(0, 1'b1, 16'h0010, 16'h0, 1'b1);
    wait_done(0, ta);
    drop_req(0);
    @(negedge clock);
    check_eq("strobe_low_after", 32'(if0.complete_data), 32'd0);

    // Write then back-to-back read of the same word.
    start_req(0, 1'b0, 16'h0020, 16'h1234, 1'b1);
    wait_done(0, ta);
    start_req(0, 1'b1, 16'h0020, 16'h0, 1'b1);
    wait_done(0, tb);
    drop_req(0);
    check_eq("b2b_spacing_l2", 32'(tb - ta), 32'(L0 + 1));
    @(negedge clock);

    // Address wrap: 0x3105 aliases 0x0005.
    start_req(0, 1'b0, 16'h3105, 16'hA5A5, 1'b1);
    wait_done(0, ta);
    drop_req(0);
    @(negedge clock);
    start_req(0, 1'b1, 16'h0005, 16'h0, 1'b1);
    wait_done(0, ta);
    drop_req(0);
    @(negedge clock);

    // Abort a write in WAIT: no completion and no commit.
    start_req(0, 1'b0, 16'h0030, 16'h7777, 1'b0);
    @(negedge clock);
    drop_req(0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check_eq("abort_no_complete", 32'(if0.complete_data), 32'd0);
    end
    start_req(0, 1'b1, 16'h0030, 16'h0, 1'b1);
    wait_done(0, ta);
    drop_req(0);
    @(negedge clock);

    // Preload while busy is dropped with a one-cycle ld_err.
    start_req(0, 1'b1, 16'h0040, 16'h0, 1'b1);
    @(negedge clock);
    ld_en0 = 1'b1; ld_addr0 = 8'h40; ld_data0 = 16'hDEAD;
    @(negedge clock);
    check_eq("ld_err_busy", 32'(ld_err0), 32'd1);
    ld_en0 = 1'b0;
    @(negedge clock);
    check_eq("ld_err_pulse_end", 32'(ld_err0), 32'd0);
    drop_req(0);
    @(negedge clock);
    start_req(0, 1'b1, 16'h0040, 16'h0, 1'b1);
    wait_done(0, ta);
    drop_req(0);
    @(negedge clock);

    // Preload and request in the same idle cycle: read sees the preload.
    ld_en0 = 1'b1; ld_addr0 = 8'h08; ld_data0 = 16'h0808; mem0[8] = 16'h0808;
    start_req(0, 1'b1, 16'h0008, 16'h0, 1'b1);
    @(negedge clock);
    ld_en0 = 1'b0;
    wait_done(0, ta);
    drop_req(0);
    @(negedge clock);

    // Reset mid-WAIT: outputs clear asynchronously, pending write dropped.
    start_req(0, 1'b0, 16'h0050, 16'h9999, 1'b0);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_eq("midrst_complete", 32'(if0.complete_data), 32'd0);
    check_eq("midrst_dout",     32'(if0.data_dout),     32'h0000);
    check_eq("midrst_ld_err",   32'(ld_err0),           32'd0);
    md0 = '0;
    md1 = '0;
    drop_req(0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    start_req(0, 1'b1, 16'h0050, 16'h0, 1'b1);
    wait_done(0, ta);
    drop_req(0);
    @(negedge clock);

    // LATENCY=1 instance: read, then write/read back-to-back.
    preload(1, 8'h07, 16'hCAFE);
    start_req(1, 1'b1, 16'h0007, 16'h0, 1'b1);
    wait_done(1, ta);
    drop_req(1);
    @(negedge clock);
    start_req(1, 1'b0, 16'h0109, 16'h1357, 1'b1);
    wait_done(1, ta);
    start_req(1, 1'b1, 16'h0009, 16'h0, 1'b1);
    wait_done(1, tb);
    drop_req(1);
    check_eq("b2b_spacing_l1", 32'(tb - ta), 32'(L1 + 1));

    repeat (4) @(negedge clock);
    check_eq("scoreboard_l2_drained", 32'(q0.size()), 32'd0);
    check_eq("scoreboard_l1_drained", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3_dmem_responder.md
# lc3_dmem_responder

Synthesizable data-memory responder for the LC3 bench: it sits on the far end of the DUT's MemAccess data-memory port, answering reads and accepting writes after a programmable latency with a single-cycle `complete_data` strobe. It replaces the bench-side dmem agent when running the LC3 top with a realistic memory. It also provides a side-band preload port so a test can initialise memory contents before releasing the DUT.

## Interface
Parameters:
- `ADDR_LSB_W`, 8: implemented address bits; depth = 2^ADDR_LSB_W words.
- `LATENCY`, 2: cycles from an accepted request to `complete_data`; legal range 1..15.

Ports:
- `clock`  in  1  single clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `data_req`  in  1  DUT request valid; held high until `complete_data`.
- `data_rd`  in  1  1 = read, 0 = write; sampled with `data_req`.
- `data_addr`  in  16  word address; only `[ADDR_LSB_W-1:0]` is used.
- `data_din`  in  16  write data from the DUT.
- `data_dout`  out  16  read data to the DUT.
- `complete_data`  out  1  one-cycle completion strobe.
- `ld_en`  in  1  preload write enable.
- `ld_addr`  in  ADDR_LSB_W  preload address.
- `ld_data`  in  16  preload data.
- `ld_err`  out  1  pulses when `ld_en` is dropped because the FSM is busy.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE: with `data_req`=1, latch `data_rd`, the address low bits and `data_din`, load `cnt` with LATENCY-1, then go to WAIT. If LATENCY=1, go straight to DONE.
- WAIT: decrement `cnt`.
  - `cnt`=0 -> DONE.
  - `data_req`=0 at any point -> abort to IDLE. No write, no `complete_data`.
- DONE: assert `complete_data` for one cycle.
  - Read: `data_dout` = array[latched addr].
  - Write: array[latched addr] = latched `din`; `data_dout` keeps its previous value.
  - Next state is always IDLE.
- Addresses wrap modulo 2^ADDR_LSB_W. Example with ADDR_LSB_W=8: 0x3105 aliases 0x0005.
- Preload: `ld_en` is honoured only in IDLE, and writes `ld_data` to `ld_addr` that cycle.
  - `ld_en` in WAIT or DONE is ignored and `ld_err`=1 for that cycle.
  - `ld_en` and a new `data_req` in the same IDLE cycle: the preload is written, and the request is accepted with the pre-write array contents irrelevant, because the read happens in DONE and sees the preloaded value.
- Request fields are latched. Changes to `data_addr`, `data_din` or `data_rd` after acceptance are ignored.

## Timing
- Reset values: state IDLE, `cnt` 0, `complete_data` 0, `data_dout` 16'h0000, `ld_err` 0. Array contents are not reset.
- Reset asserted mid-transaction aborts it immediately with outputs at reset values. A pending write is not committed.
- Request accepted at edge N -> `complete_data` high in cycle N+LATENCY. `data_dout` is registered and valid in that same cycle, then held until the next read completion.
- After DONE there is one mandatory IDLE cycle. Back-to-back requests therefore complete every LATENCY+1 cycles.
- `complete_data` is never high in two consecutive cycles.
- Array: synchronous write, combinational read, registered into `data_dout`.

## Structure
- Shared package `lc3_dmem_pkg`:
  - `dmem_state_t` enum {IDLE, WAIT, DONE};
  - `lc3_word_t` = logic [15:0];
  - localparam `LAT_MAX` = 15.
- Sub-module `lc3_dmem_array`: single write port (muxed between preload and DUT write) and one async read port. It has no reset.
- Top module holds the FSM, latency counter, request latches and output registers.

## Test plan
- Preload 0x0010 <- 16'hBEEF; read 0x0010 with LATENCY=2, request at edge 5 -> `complete_data` at cycle 7 with `data_dout`=16'hBEEF; strobe width 1.
- Write 16'h1234 to 0x0020, then read 0x0020 -> first completion leaves `data_dout` unchanged; second returns 16'h1234; completions are exactly LATENCY+1 cycles apart.
- Address wrap, ADDR_LSB_W=8: write 16'hA5A5 to 0x3105, read 0x0005 -> 16'hA5A5.
- Drop `data_req` in WAIT on a write of 16'h7777 to 0x0030 -> no `complete_data`; a later read of 0x0030 returns the previous preload value.
- `ld_en` during WAIT -> `ld_err`=1 for one cycle and the target location is unchanged. `reset_n` low mid-WAIT -> outputs go to 0 asynchronously and the FSM is in IDLE after release.
- LATENCY=1: a read request at edge N -> `complete_data` at cycle N+1.
